// File: rtl/axi_full_pkg.sv
// Shared encodings for the AXI4 burst SRAM slave: burst types, responses, beat size and FSM states.
package axi_full_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [2:0] SIZE_8B     = 3'd3;
   localparam int unsigned BEAT_BYTES = 8;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   // Burst control latched at address acceptance
   typedef struct packed {
      logic [7:0] len;
      logic [1:0] burst;
   } burst_ctl_t;

   // Only 2, 4, 8 and 16 beat wraps are legal; anything else is treated as INCR
   function automatic logic wrap_len_legal(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts of 8-byte beats.
module axi_burst_addr
   import axi_full_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  burst_ctl_t        ctl,
   output logic [ADDR_W-1:0] next_addr_c
);

   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] mask;

   always_comb begin
      base        = {addr[ADDR_W-1:3], 3'b000};
      incr        = base + ADDR_W'(BEAT_BYTES);
      mask        = ADDR_W'({ctl.len[3:0], 3'b111});
      next_addr_c = incr;
      case (ctl.burst)
         BURST_FIXED: next_addr_c = addr;
         BURST_WRAP: begin
            if (wrap_len_legal(ctl.len))
               next_addr_c = (base & ~mask) | (incr & mask);
         end
         default: next_addr_c = incr;
      endcase
   end

endmodule

// File: rtl/axi_full_slv_burst_sram.sv
// AXI4-full burst SRAM slave with independent read/write FSMs.
// Define AXI_SLV_RDLAT_EN to add RD_LAT wait cycles before the first read beat.
module axi_full_slv_burst_sram
   import axi_full_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned DEPTH_W = 12,
   parameter int unsigned RD_LAT  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
   input  logic [7:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [DATA_W-1:0]     S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
   input  logic                  S_AXI_WLAST,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
   input  logic [7:0]            S_AXI_ARLEN,
   input  logic [2:0]            S_AXI_ARSIZE,
   input  logic [1:0]            S_AXI_ARBURST,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [DATA_W-1:0]     S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RLAST,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned WORDS  = 1 << DEPTH_W;

   logic [DATA_W-1:0] mem [WORDS];

   // SIZE is always treated as 8 bytes and WLAST never terminates a burst
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWSIZE ^ SIZE_8B, S_AXI_ARSIZE ^ SIZE_8B, S_AXI_WLAST};

   // ---------------- write channel ----------------
   w_state_t          w_state;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] wr_next_c;
   burst_ctl_t        wr_ctl;
   logic [7:0]        wr_beat;
   logic              wr_fire_c;

   assign wr_fire_c = S_AXI_WVALID && S_AXI_WREADY;

   axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
      .addr        (wr_addr),
      .ctl         (wr_ctl),
      .next_addr_c (wr_next_c)
   );

   // Byte-lane writes; no reset so contents survive RST
   always_ff @(posedge CLK) begin
      if (wr_fire_c) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b])
               mem[wr_addr[DEPTH_W+2:3]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         w_state       <= W_IDLE;
         S_AXI_AWREADY <= 1'b1;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         wr_addr       <= '0;
         wr_ctl        <= '0;
         wr_beat       <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                  wr_addr       <= S_AXI_AWADDR;
                  wr_ctl        <= '{len: S_AXI_AWLEN, burst: S_AXI_AWBURST};
                  wr_beat       <= '0;
                  S_AXI_AWREADY <= 1'b0;
                  S_AXI_WREADY  <= 1'b1;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (wr_fire_c) begin
                  wr_addr <= wr_next_c;
                  wr_beat <= wr_beat + 8'd1;
                  if (wr_beat == wr_ctl.len) begin
                     S_AXI_WREADY <= 1'b0;
                     S_AXI_BVALID <= 1'b1;
                     S_AXI_BRESP  <= RESP_OKAY;
                     w_state      <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID  <= 1'b0;
                  S_AXI_AWREADY <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- read channel ----------------
   r_state_t          r_state;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] rd_src_addr_c;
   logic [ADDR_W-1:0] rd_next_c;
   burst_ctl_t        rd_ctl;
   burst_ctl_t        rd_src_ctl_c;
   logic [7:0]        rd_beat;
   logic [DEPTH_W-1:0] rd_idx_c;

`ifdef AXI_SLV_RDLAT_EN
   localparam int unsigned LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int unsigned WAIT_LAST = (RD_LAT > 0) ? RD_LAT - 1 : 0;
   logic [LAT_W-1:0] rd_wait;
`else
   localparam int unsigned unused_rd_lat = RD_LAT;
`endif

   // In idle the incoming descriptor drives the address path so beat 0 loads on acceptance
   always_comb begin
      rd_src_addr_c = rd_addr;
      rd_src_ctl_c  = rd_ctl;
      if (r_state == R_IDLE) begin
         rd_src_addr_c = S_AXI_ARADDR;
         rd_src_ctl_c  = '{len: S_AXI_ARLEN, burst: S_AXI_ARBURST};
      end
      rd_idx_c = rd_src_addr_c[DEPTH_W+2:3];
   end

   axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
      .addr        (rd_src_addr_c),
      .ctl         (rd_src_ctl_c),
      .next_addr_c (rd_next_c)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b1;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
         S_AXI_RLAST   <= 1'b0;
         rd_addr       <= '0;
         rd_ctl        <= '0;
         rd_beat       <= '0;
`ifdef AXI_SLV_RDLAT_EN
         rd_wait       <= '0;
`endif
      end else begin
         case (r_state)
            R_IDLE: begin
               if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                  rd_ctl        <= rd_src_ctl_c;
                  rd_beat       <= '0;
                  S_AXI_ARREADY <= 1'b0;
`ifdef AXI_SLV_RDLAT_EN
                  rd_addr       <= S_AXI_ARADDR;
                  rd_wait       <= '0;
                  r_state       <= R_WAIT;
`else
                  rd_addr       <= rd_next_c;
                  S_AXI_RDATA   <= mem[rd_idx_c];
                  S_AXI_RRESP   <= RESP_OKAY;
                  S_AXI_RLAST   <= (rd_src_ctl_c.len == 8'd0);
                  S_AXI_RVALID  <= 1'b1;
                  r_state       <= R_DATA;
`endif
               end
            end
`ifdef AXI_SLV_RDLAT_EN
            R_WAIT: begin
               if (rd_wait == LAT_W'(WAIT_LAST)) begin
                  rd_addr      <= rd_next_c;
                  S_AXI_RDATA  <= mem[rd_idx_c];
                  S_AXI_RRESP  <= RESP_OKAY;
                  S_AXI_RLAST  <= (rd_ctl.len == 8'd0);
                  S_AXI_RVALID <= 1'b1;
                  r_state      <= R_DATA;
               end else begin
                  rd_wait <= rd_wait + LAT_W'(1);
               end
            end
`endif
            R_DATA: begin
               // Outputs only move on a handshake, so stalls hold them stable
               if (S_AXI_RREADY) begin
                  if (S_AXI_RLAST) begin
                     S_AXI_RVALID  <= 1'b0;
                     S_AXI_RLAST   <= 1'b0;
                     S_AXI_ARREADY <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     S_AXI_RDATA <= mem[rd_idx_c];
                     S_AXI_RLAST <= ((rd_beat + 8'd1) == rd_ctl.len);
                     rd_addr     <= rd_next_c;
                     rd_beat     <= rd_beat + 8'd1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_full_slv_burst_sram.sv
// Self-checking bench for axi_full_slv_burst_sram: directed scenarios plus randomized bursts
// checked against a word-array reference model. Honours AXI_SLV_RDLAT_EN for read latency.
module tb_axi_full_slv_burst_sram;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned WORDS  = 4096;
   localparam int unsigned RD_LAT = 4;
`ifdef AXI_SLV_RDLAT_EN
   localparam int unsigned EXP_LAT = RD_LAT + 1;
`else
   localparam int unsigned EXP_LAT = 1;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [ADDR_W-1:0] AWADDR = '0;
   logic [7:0]        AWLEN = '0;
   logic [2:0]        AWSIZE = 3'd3;
   logic [1:0]        AWBURST = '0;
   logic              AWVALID = 1'b0;
   logic              AWREADY;
   logic [63:0]       WDATA = '0;
   logic [7:0]        WSTRB = '0;
   logic              WLAST = 1'b0;
   logic              WVALID = 1'b0;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY = 1'b0;
   logic [ADDR_W-1:0] ARADDR = '0;
   logic [7:0]        ARLEN = '0;
   logic [2:0]        ARSIZE = 3'd3;
   logic [1:0]        ARBURST = '0;
   logic              ARVALID = 1'b0;
   logic              ARREADY;
   logic [63:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY = 1'b0;

   int vectors     = 0;
   int miscompares = 0;
   logic [63:0] ref_mem [WORDS];

   axi_full_slv_burst_sram #(
      .ADDR_W(32), .DATA_W(64), .DEPTH_W(12), .RD_LAT(RD_LAT)
   ) dut (
      .CLK(CLK), .RST(RST),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
      .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST),
      .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
      .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
      .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word touched by beat i, derived from AXI burst rules on word indices
   function automatic int unsigned beat_word(input logic [31:0] addr, input int unsigned len,
                                             input logic [1:0] burst, input int unsigned i);
      int unsigned sw;
      int unsigned n;
      sw = (addr >> 3) % WORDS;
      n  = len + 1;
      if (burst == 2'b00) return sw;
      if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
         return (sw - (sw % n)) + ((sw % n) + i) % n;
      return (sw + i) % WORDS;
   endfunction

   task automatic wr_burst(input logic [31:0] addr, input int unsigned len, input logic [1:0] burst,
                           input logic [63:0] data[$], input logic [7:0] strb[$], input bit gaps);
      bit hs;
      int n;
      int unsigned w;
      AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      do begin hs = AWREADY; @(posedge CLK); #1; n++; end while (!hs && n < 50);
      AWVALID = 1'b0;
      check("aw_accept", 64'(hs), 64'd1);
      if (!hs) return;
      for (int i = 0; i <= int'(len); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
         WDATA = data[i]; WSTRB = strb[i]; WLAST = (i == int'(len)); WVALID = 1'b1;
         n = 0;
         do begin hs = WREADY; @(posedge CLK); #1; n++; end while (!hs && n < 50);
         WVALID = 1'b0; WLAST = 1'b0;
         if (!hs) begin check("w_accept", 64'd0, 64'd1); return; end
         w = beat_word(addr, len, burst, i);
         for (int b = 0; b < 8; b++)
            if (strb[i][b]) ref_mem[w][b*8 +: 8] = data[i][b*8 +: 8];
      end
      check("bvalid_after_last", 64'(BVALID), 64'd1);
      check("bresp", 64'(BRESP), 64'd0);
      repeat ($urandom_range(0, 2)) begin
         @(posedge CLK); #1;
         check("bvalid_hold", 64'(BVALID), 64'd1);
      end
      BREADY = 1'b1; @(posedge CLK); #1; BREADY = 1'b0;
      check("bvalid_clear", 64'(BVALID), 64'd0);
      check("awready_back", 64'(AWREADY), 64'd1);
   endtask

   // mode 0: RREADY always 1, 1: random, 2: pattern 1,0,0,1,0,0,...
   task automatic rd_burst(input logic [31:0] addr, input int unsigned len, input logic [1:0] burst,
                           input int unsigned mode);
      bit hs;
      bit rr;
      int n;
      int unsigned lat;
      int unsigned beat;
      int unsigned cyc;
      ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      do begin hs = ARREADY; @(posedge CLK); #1; n++; end while (!hs && n < 50);
      ARVALID = 1'b0;
      check("ar_accept", 64'(hs), 64'd1);
      if (!hs) return;
      lat = 1;
      while (!RVALID && lat < 50) begin @(posedge CLK); #1; lat++; end
      check("r_latency", 64'(lat), 64'(EXP_LAT));
      if (!RVALID) return;
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 500) begin
         check("rvalid", 64'(RVALID), 64'd1);
         check("rdata", RDATA, ref_mem[beat_word(addr, len, burst, beat)]);
         check("rlast", 64'(RLAST), 64'(beat == len));
         check("rresp", 64'(RRESP), 64'd0);
         rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
         RREADY = rr;
         @(posedge CLK); #1;
         cyc++;
         if (rr) beat++;
      end
      RREADY = 1'b0;
      check("r_beats", 64'(beat), 64'(len + 1));
      check("rvalid_end", 64'(RVALID), 64'd0);
      check("arready_back", 64'(ARREADY), 64'd1);
   endtask

   initial begin
      logic [63:0] dq[$];
      logic [7:0]  sq[$];
      logic [63:0] dq2[$];
      logic [7:0]  sq2[$];
      bit hs;
      int n;
      int unsigned len;
      int unsigned w;
      int unsigned kind;
      logic [1:0]  burst;
      logic [31:0] addr;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_awready", 64'(AWREADY), 64'd1);
      check("rst_arready", 64'(ARREADY), 64'd1);
      check("rst_wready", 64'(WREADY), 64'd0);
      check("rst_bvalid", 64'(BVALID), 64'd0);
      check("rst_bresp", 64'(BRESP), 64'd0);
      check("rst_rvalid", 64'(RVALID), 64'd0);
      check("rst_rlast", 64'(RLAST), 64'd0);
      check("rst_rresp", 64'(RRESP), 64'd0);
      check("rst_rdata", RDATA, 64'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // 1: INCR write/read of 0..7
      dq = {}; sq = {};
      for (int i = 0; i < 8; i++) begin dq.push_back(64'(i)); sq.push_back(8'hFF); end
      wr_burst(32'h0, 7, 2'b01, dq, sq, 1'b0);
      rd_burst(32'h0, 7, 2'b01, 0);

      // 2: WRAP len=3 from 0x18
      rd_burst(32'h18, 3, 2'b10, 0);

      // 3: partial strobe over word 4
      dq = {64'hFFFF_FFFF_FFFF_FFFF}; sq = {8'h0F};
      wr_burst(32'h20, 0, 2'b01, dq, sq, 1'b0);
      rd_burst(32'h20, 0, 2'b01, 0);

      // 4: RREADY stalls
      rd_burst(32'h0, 3, 2'b01, 2);

      // 5: reset during beat 2 of a len=7 write at 0x800
      AWADDR = 32'h800; AWLEN = 8'd7; AWBURST = 2'b01; AWVALID = 1'b1;
      n = 0;
      do begin hs = AWREADY; @(posedge CLK); #1; n++; end while (!hs && n < 50);
      AWVALID = 1'b0;
      check("rst_aw_accept", 64'(hs), 64'd1);
      for (int i = 0; i < 2; i++) begin
         WDATA = {$urandom, $urandom}; WSTRB = 8'hFF; WVALID = 1'b1;
         n = 0;
         do begin hs = WREADY; @(posedge CLK); #1; n++; end while (!hs && n < 50);
         check("rst_w_accept", 64'(hs), 64'd1);
         ref_mem[256 + i] = WDATA;
      end
      WDATA = {$urandom, $urandom}; WVALID = 1'b1; RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; WVALID = 1'b0;
      check("midrst_bvalid", 64'(BVALID), 64'd0);
      check("midrst_wready", 64'(WREADY), 64'd0);
      check("midrst_awready", 64'(AWREADY), 64'd1);
      @(posedge CLK); #1;
      check("midrst_awready_next", 64'(AWREADY), 64'd1);
      rd_burst(32'h800, 1, 2'b01, 0);
      dq = {}; sq = {};
      for (int i = 0; i < 8; i++) begin dq.push_back({$urandom, $urandom}); sq.push_back(8'hFF); end
      wr_burst(32'h800, 7, 2'b01, dq, sq, 1'b1);
      rd_burst(32'h800, 7, 2'b01, 1);

      // Fill words 0..255 so random reads only see defined data
      for (int blk = 0; blk < 16; blk++) begin
         dq = {}; sq = {};
         for (int i = 0; i < 16; i++) begin dq.push_back({$urandom, $urandom}); sq.push_back(8'hFF); end
         wr_burst(32'(blk * 128), 15, 2'b01, dq, sq, 1'b0);
      end

      // Randomized bursts with aliased high address bits and ignored low bits
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: begin burst = 2'b00; len = $urandom_range(0, 15); w = $urandom_range(0, 255); end
            1: begin burst = 2'b01; len = $urandom_range(0, 15); w = $urandom_range(0, 255 - len); end
            2: begin burst = 2'b10; len = (2 << $urandom_range(0, 3)) - 1; w = $urandom_range(0, 255); end
            default: begin
               burst = 2'b10; len = 2 * $urandom_range(1, 6); w = $urandom_range(0, 255 - len);
            end
         endcase
         addr = ($urandom & 32'hFFFF_8000) | 32'(w << 3) | 32'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            dq = {}; sq = {};
            for (int i = 0; i <= int'(len); i++) begin
               dq.push_back({$urandom, $urandom});
               sq.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
            end
            wr_burst(addr, len, burst, dq, sq, 1'b1);
         end else begin
            rd_burst(addr, len, burst, $urandom_range(0, 1));
         end
      end

      // AW and AR offered together on disjoint regions
      for (int t = 0; t < 4; t++) begin
         dq2 = {}; sq2 = {};
         for (int i = 0; i < 8; i++) begin dq2.push_back({$urandom, $urandom}); sq2.push_back(8'hFF); end
         fork
            wr_burst(32'h400 + 32'(t * 64), 7, 2'b01, dq2, sq2, 1'b1);
            rd_burst(32'h000 + 32'(t * 64), 7, 2'b10, 1);
         join
      end
      rd_burst(32'h400, 15, 2'b01, 0);
      rd_burst(32'h440, 15, 2'b01, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_full_slv_burst_sram.md
Name: axi_full_slv_burst_sram

Overview:
AXI4-full slave memory model that sits directly downstream of the cache's MEM_* master port and terminates its line-fill and write-back bursts. Supports INCR, WRAP and FIXED bursts on a 64-bit data path with byte strobes. The read and write channels are independent. This block replaces the simple SRAM model in cache-level benches, adding burst-accurate addressing and backpressure handling.

Parameters:
ADDR_W, 32, AXI address width in bits.
DATA_W, 64, data width in bits; fixed at 64 (8-byte beats).
DEPTH_W, 12, log2 of the memory depth in 64-bit words (4096 words = 32 KiB).
RD_LAT, 4, wait cycles between AR acceptance and the first R beat (used only with the optional feature).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write burst start byte address
S_AXI_AWLEN  in  8  write beats minus 1
S_AXI_AWSIZE  in  3  beat size; 3'd3 expected
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  64  write data
S_AXI_WSTRB  in  8  byte enables
S_AXI_WLAST  in  1  last write beat (informational)
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  ADDR_W/8/3/2  read burst descriptor
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  64  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake

Behaviour:
- Reset (asynchronous, RST=1): all outputs 0 except AWREADY=1 and ARREADY=1. Both FSMs go to IDLE and any in-flight burst is abandoned. Memory contents are not cleared.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch address, len and burst, clear the beat counter, then go to W_DATA with AWREADY=0.
  - W_DATA: WREADY=1. On each W handshake, write the bytes selected by WSTRB to word addr[DEPTH_W+2:3] and advance the address.
  - When beat counter == len: go to W_RESP. WLAST is ignored for termination.
  - W_RESP: BVALID=1 with BRESP=2'b00 until BREADY, then return to W_IDLE. Minimum latency is 1 cycle from the last W beat to BVALID.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch the descriptor and go to R_DATA.
  - R_DATA: RVALID=1 and RRESP=2'b00. RDATA is the memory word at the current address, registered.
  - First beat: RVALID rises in the cycle after AR acceptance.
  - Stalls: RDATA, RLAST and RVALID hold stable while RREADY=0.
  - RLAST=1 exactly on beat == len. The handshake on that beat returns the FSM to R_IDLE.
- Address arithmetic (shared by both channels):
  - FIXED: address unchanged.
  - INCR: address += 8.
  - WRAP: boundary = (len+1)*8 bytes; next = (addr & ~(boundary-1)) | ((addr+8) & (boundary-1)).
  - Legal WRAP lengths are 2, 4, 8 and 16 beats; other WRAP lengths behave as INCR.
  - Addresses alias modulo 2^(DEPTH_W+3). The low 3 address bits are ignored; SIZE is treated as 3.
- Same-word read and write in one cycle: the read returns the old data (read-before-write).
- AR and AW accepted in the same cycle: both proceed independently.
- No outstanding transactions: one active burst per channel.

Optional Feature:
AXI_SLV_RDLAT_EN
- Defined: the read FSM gains an R_WAIT state between R_IDLE and R_DATA, in which a counter runs for RD_LAT cycles. The first RVALID therefore rises RD_LAT+1 cycles after AR acceptance. Subsequent beats have no added wait.
- Undefined: R_WAIT is absent, the latency is 1 cycle and RD_LAT is unused.

Decomposition:
- Package axi_full_pkg: burst encodings (FIXED/INCR/WRAP), response codes (OKAY=2'b00), beat size constant (3'd3), and the FSM state encodings for the W and R FSMs.
- One sub-module, axi_burst_addr: combinational next-address calculation from (addr, len, burst), instantiated once per channel.

Test Plan:
1. Write INCR, len=7, AWADDR=0x00, data 0x0..0x7, WSTRB=0xFF; then read INCR len=7 at 0x00 -> RDATA 0x0..0x7, RLAST on beat 7 only, BRESP=0 and RRESP=0.
2. Read WRAP, len=3, ARADDR=0x18 after scenario 1 -> beats return words at 0x18, 0x00, 0x08, 0x10 (data 3, 0, 1, 2).
3. Single write 0xFFFF_FFFF_FFFF_FFFF at 0x20 with WSTRB=0x0F over existing 0x4 -> read back 0x0000_0000_FFFF_FFFF.
4. Read INCR len=3 with RREADY toggling 1,0,0,1,… -> no beat lost or duplicated, RDATA stable across stalls, exactly 4 handshakes.
5. Assert RST for 1 cycle during beat 2 of a write burst of len=7 -> BVALID=0, AWREADY=1 next cycle, beats 0-1 stay written, and a new burst is accepted normally.
6. With AXI_SLV_RDLAT_EN defined and RD_LAT=4 -> first RVALID appears 5 cycles after the AR handshake; without it -> 1 cycle.
